// File: rtl/engine_reg_access_bridge.sv
// ---------------------------------------------------------------------------
// engine_reg_access_bridge
//
// Upstream request/response bridge for the engine controlling-register block.
// Requests arrive on a valid/ready channel and are queued in a small FIFO.
// Each queued request is replayed as a single-cycle address/strobe on the
// register bus. One response per request is returned in request order on a
// valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. A producer holds valid and its payload stable until that
// edge. rsp_valid/rsp_* stay stable from assertion until the rsp handshake.
//
// Optional feature macro: ENGINE_REG_BRIDGE_ADDR_CHECK_EN
//   defined   : only VALID_ADDR_0 / VALID_ADDR_1 are strobed; other addresses
//               run through ACCESS with no strobe and answer rsp_error=1.
//   undefined : every address is strobed and rsp_error stays 0.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready = FIFO not full)
//   req_write/addr/wdata    request payload (1 = write)
//   address, write_enable,
//   write_data, read_enable registered register-bus outputs
//   read_data               combinational read data from the register block
//   rsp_valid/rsp_ready     response handshake
//   rsp_write/rdata/error   response payload
//   pending                 FIFO occupancy
//   dbg_state               current FSM state (debug observation)
// ---------------------------------------------------------------------------
module engine_reg_access_bridge #(
  parameter int ADDR_WIDTH  = 33,
  parameter int WDATA_WIDTH = 33,
  parameter int RDATA_WIDTH = 21,
  parameter int REQ_DEPTH   = 4
`ifdef ENGINE_REG_BRIDGE_ADDR_CHECK_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] VALID_ADDR_0 = 'hAA,
  parameter logic [ADDR_WIDTH-1:0] VALID_ADDR_1 = 'h55
`endif
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [WDATA_WIDTH-1:0]         req_wdata,
  output logic [ADDR_WIDTH-1:0]          address,
  output logic                           write_enable,
  output logic [WDATA_WIDTH-1:0]         write_data,
  output logic                           read_enable,
  input  logic [RDATA_WIDTH-1:0]         read_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_write,
  output logic [RDATA_WIDTH-1:0]         rsp_rdata,
  output logic                           rsp_error,
  output logic [$clog2(REQ_DEPTH):0]     pending,
  output logic [1:0]                     dbg_state
);

  localparam int PTR_W   = $clog2(REQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + WDATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // FIFO storage and pointers
  logic [ENTRY_W-1:0]     mem_q [REQ_DEPTH];
  logic [ENTRY_W-1:0]     mem_d [REQ_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // FSM and bus/response registers
  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [WDATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                   write_enable_q, write_enable_d;
  logic                   read_enable_q, read_enable_d;
  logic                   cur_write_q, cur_write_d;
  logic                   cur_err_q, cur_err_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_write_q, rsp_write_d;
  logic [RDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_error_q, rsp_error_d;

  logic                   full, empty, push, pop;
  logic                   head_write;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [WDATA_WIDTH-1:0] head_wdata;
  logic                   addr_ok;

  assign full  = (count_q == CNT_W'(REQ_DEPTH));
  assign empty = (count_q == '0);
  // Gated by the raw reset so req_ready is low for the whole reset window.
  assign req_ready = reset & ~full;
  assign push      = req_valid & req_ready;
  assign {head_write, head_addr, head_wdata} = mem_q[rd_ptr_q];

`ifdef ENGINE_REG_BRIDGE_ADDR_CHECK_EN
  assign addr_ok = (head_addr == VALID_ADDR_0) || (head_addr == VALID_ADDR_1);
`else
  assign addr_ok = 1'b1;
`endif

  // FIFO next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {req_write, req_addr, req_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next-state and outputs. Strobes default low so each lasts one cycle;
  // address/write_data hold their last value between accesses.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    address_d      = address_q;
    write_data_d   = write_data_q;
    write_enable_d = 1'b0;
    read_enable_d  = 1'b0;
    cur_write_d    = cur_write_q;
    cur_err_d      = cur_err_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_write_d    = rsp_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_error_d    = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop            = 1'b1;
          address_d      = head_addr;
          write_data_d   = head_wdata;
          cur_write_d    = head_write;
          cur_err_d      = ~addr_ok;
          // An undecoded address still spends its ACCESS cycle, unstrobed.
          write_enable_d = head_write & addr_ok;
          read_enable_d  = ~head_write & addr_ok;
          state_d        = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = cur_write_q;
        rsp_rdata_d = read_enable_q ? read_data : '0;
        // Constant 0 when the address check is compiled out.
        rsp_error_d = cur_err_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REQ_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      address_q      <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      cur_write_q    <= 1'b0;
      cur_err_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_error_q    <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      address_q      <= address_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      cur_write_q    <= cur_write_d;
      cur_err_q      <= cur_err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign address      = address_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;
  assign read_enable  = read_enable_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_error    = rsp_error_q;
  assign pending      = count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_engine_reg_access_bridge.sv
// ---------------------------------------------------------------------------
// tb_engine_reg_access_bridge
//
// Directed steps followed by a randomized phase. A small register block model
// drives read_data from its own storage, updated only by DUT write strobes.
// A separate reference model computes, at request acceptance, the expected
// response (from the bridge's documented rules) and the expected bus strobe.
// ---------------------------------------------------------------------------
module tb_engine_reg_access_bridge;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [32:0] req_addr;
  logic [32:0] req_wdata;
  logic [32:0] address;
  logic        write_enable;
  logic [32:0] write_data;
  logic        read_enable;
  logic [20:0] read_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [20:0] rsp_rdata;
  logic        rsp_error;
  logic [2:0]  pending;
  logic [1:0]  dbg_state;

  engine_reg_access_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .address(address), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .pending(pending), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register block model ----------------
  logic [20:0] blk [8];
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [20:0] pl_val;

  assign read_data = blk[address[2:0]];

  always @(posedge clock) begin
    if (pl_en) blk[pl_idx] <= pl_val;
    else if (write_enable) blk[address[2:0]] <= write_data[20:0];
  end

  // ---------------- reference model / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  logic [20:0] model_regs [8];
  logic [22:0] exp_q [$];      // {write, error, rdata}
  logic [66:0] strobe_q [$];   // {write, addr, wdata}

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [32:0] a);
`ifdef ENGINE_REG_BRIDGE_ADDR_CHECK_EN
    return !(a == 33'h0AA || a == 33'h055);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [32:0] addr_tab(input int i);
    case (i)
      0: return 33'h1_2345_6780;
      1: return 33'h0_0000_0011;
      2: return 33'h0_0000_00AA;
      3: return 33'h1_FFFF_FFF3;
      4: return 33'h0_8000_0004;
      5: return 33'h0_0000_0055;
      6: return 33'h1_0000_00AE;
      default: return 33'h0_DEAD_BEE7;
    endcase
  endfunction

  // Samples on the falling edge: inputs are driven just after rising edges,
  // so what is seen here is what the next rising edge will act on.
  logic        m_err;
  logic [20:0] m_rd;
  logic [66:0] m_s;
  logic [22:0] m_e;
  always @(negedge clock) begin
    if (reset) begin
      if (req_valid && req_ready) begin
        acc_cnt++;
        m_err = addr_err(req_addr);
        m_rd  = '0;
        if (req_write) begin
          if (!m_err) model_regs[req_addr[2:0]] = req_wdata[20:0];
        end else if (!m_err) begin
          m_rd = model_regs[req_addr[2:0]];
        end
        exp_q.push_back({req_write, m_err, m_rd});
        if (!m_err) strobe_q.push_back({req_write, req_addr, req_wdata});
      end
      if (write_enable || read_enable) begin
        check("strobe_expected", 67'(strobe_q.size() != 0), 67'(1));
        if (strobe_q.size() != 0) begin
          m_s = strobe_q.pop_front();
          check("strobe_kind", 67'({write_enable, read_enable}), 67'({m_s[66], ~m_s[66]}));
          check("strobe_addr", 67'(address), 67'(m_s[65:33]));
          check("strobe_wdata", 67'(write_data), 67'(m_s[32:0]));
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        check("rsp_expected", 67'(exp_q.size() != 0), 67'(1));
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("rsp_payload", 67'({rsp_write, rsp_error, rsp_rdata}), 67'(m_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [20:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    model_regs[idx] = val;
    step();
    pl_en = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_req(input logic w, input logic [32:0] a, input logic [32:0] d);
    int  prev;
    bit  done;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      prev = acc_cnt;
      step();
      if (acc_cnt != prev) done = 1'b1;
    end
    req_valid = 1'b0;
    check("req_accepted", 67'(done), 67'(1));
  endtask

  task automatic drain(input string tag);
    step();
    rsp_ready = 1'b1;
    for (int n = 0; n < 300 && (exp_q.size() != 0 || pending != 0 || rsp_valid); n++) step();
    check({tag, "_rsp_left"}, 67'(exp_q.size()), 67'(0));
    check({tag, "_strobe_left"}, 67'(strobe_q.size()), 67'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  int prev_acc, prev_rsp, seen, target, prev;
  logic [20:0] exp_rd;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    #2 reset = 1'b0;
    #2;
    check("rst_req_ready", 67'(req_ready), 67'(0));
    check("rst_rsp_valid", 67'(rsp_valid), 67'(0));
    check("rst_strobes", 67'({write_enable, read_enable}), 67'(0));
    check("rst_pending", 67'(pending), 67'(0));
    check("rst_address", 67'(address), 67'(0));
    check("rst_rsp", 67'({rsp_write, rsp_error, rsp_rdata}), 67'(0));
    for (int i = 0; i < 8; i++) preload(3'(i), 21'h15A5A ^ 21'(i * 'h321));
    @(negedge clock); #2 reset = 1'b1;
    step();
    check("post_rst_ready", 67'(req_ready), 67'(1));

    // Write with exact strobe timing
    drive_req(1'b1, 33'h0AA, 33'h1234);
    @(negedge clock);
    check("wr_e0_pending", 67'(pending), 67'(1));
    check("wr_e0_nostrobe", 67'(write_enable), 67'(0));
    @(negedge clock);
    check("wr_e1_strobe", 67'({write_enable, read_enable}), 67'(2'b10));
    check("wr_e1_addr", 67'(address), 67'(33'h0AA));
    check("wr_e1_data", 67'(write_data), 67'(33'h1234));
    @(negedge clock);
    check("wr_e2_strobe_off", 67'(write_enable), 67'(0));
    check("wr_e2_rsp", 67'({rsp_valid, rsp_write, rsp_error, rsp_rdata}), 67'({3'b110, 21'h0}));
    drain("wr");

    // Read with captured data
    preload(3'd2, 21'h0ABCD);
    drive_req(1'b0, 33'h0AA, 33'h1_5555_0000);
    @(negedge clock);
    @(negedge clock);
    check("rd_e1_strobe", 67'({write_enable, read_enable}), 67'(2'b01));
    check("rd_e1_addr", 67'(address), 67'(33'h0AA));
    @(negedge clock);
    check("rd_e2_rsp", 67'({rsp_valid, rsp_write, rsp_error, rsp_rdata}), 67'({3'b100, 21'h0ABCD}));
    drain("rd");

    // Undecoded address
    rsp_ready = 1'b0;
    exp_rd = model_regs[0];
    drive_req(1'b0, 33'h010, 33'h0);
    @(negedge clock);
    @(negedge clock);
`ifdef ENGINE_REG_BRIDGE_ADDR_CHECK_EN
    check("chk_e1_nostrobe", 67'({write_enable, read_enable}), 67'(0));
    @(negedge clock);
    check("chk_e2_rsp", 67'({rsp_valid, rsp_error, rsp_rdata}), 67'({2'b11, 21'h0}));
`else
    check("chk_e1_strobe", 67'({write_enable, read_enable}), 67'(2'b01));
    @(negedge clock);
    check("chk_e2_rsp", 67'({rsp_valid, rsp_error, rsp_rdata}), 67'({2'b10, exp_rd}));
`endif
    drain("chk");

    // Backpressure: six back-to-back offers, five fit
    rsp_ready = 1'b0;
    prev_acc = acc_cnt;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = addr_tab($urandom_range(0, 7));
      req_wdata = {1'($urandom_range(0, 1)), 32'($urandom())};
      step();
    end
    req_valid = 1'b0;
    check("bp_accepted", 67'(acc_cnt - prev_acc), 67'(5));
    @(negedge clock);
    check("bp_pending", 67'(pending), 67'(4));
    check("bp_req_ready", 67'(req_ready), 67'(0));
    prev_rsp = rsp_cnt;
    drain("bp");
    check("bp_responses", 67'(rsp_cnt - prev_rsp), 67'(5));

    // Push while popping with two entries queued
    rsp_ready = 1'b0;
    drive_req(1'b1, addr_tab(5), 33'h0_0000_0777);
    drive_req(1'b0, addr_tab(5), 33'h0);
    drive_req(1'b0, addr_tab(2), 33'h0);
    seen = 0;
    for (int n = 0; n < 20 && !rsp_valid; n++) step();
    check("pp_rsp_valid", 67'(rsp_valid), 67'(1));
    check("pp_pending_before", 67'(pending), 67'(2));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr_tab(5); req_wdata = 33'h0;
    @(negedge clock);
    check("pp_pending_idle", 67'(pending), 67'(2));
    step();
    req_valid = 1'b0;
    @(negedge clock);
    check("pp_pending_after", 67'(pending), 67'(2));
    drain("pp");

    // Reset in the middle of an access
    step();
    rsp_ready = 1'b1;
    drive_req(1'b0, 33'h0AA, 33'h0);
    @(negedge clock);
    @(negedge clock);
    #2;
    check("mid_rst_strobe_before", 67'(read_enable), 67'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_strobes", 67'({write_enable, read_enable}), 67'(0));
    check("mid_rst_rsp_valid", 67'(rsp_valid), 67'(0));
    check("mid_rst_pending", 67'(pending), 67'(0));
    check("mid_rst_req_ready", 67'(req_ready), 67'(0));
    exp_q.delete();
    strobe_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock); #2 reset = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (rsp_valid || write_enable || read_enable) seen++;
    end
    check("post_rst_quiet", 67'(seen), 67'(0));
    check("post_rst_req_ready2", 67'(req_ready), 67'(1));
    step();

    // Randomized traffic with random response backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    target = acc_cnt + 150;
    prev = acc_cnt;
    for (int cyc = 0; cyc < 6000 && acc_cnt < target; cyc++) begin
      if (!req_valid || acc_cnt != prev) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_write = 1'($urandom_range(0, 1));
        req_addr  = addr_tab($urandom_range(0, 7));
        req_wdata = {1'($urandom_range(0, 1)), 32'($urandom())};
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      prev = acc_cnt;
      step();
    end
    req_valid = 1'b0;
    check("rand_accepted", 67'(acc_cnt), 67'(target));
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
